// File: rtl/traffic_cmd_ctrl_pkg.sv
// rtl/traffic_cmd_ctrl_pkg.sv - shared types and constants for the traffic command front-end
// Purpose: FSM state encoding, table geometry and colour codes shared by the
//          command controller and the traffic_light instances it drives.
// Ports:   none (package)
package traffic_cmd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPLAY = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int          NUM_LIGHTS   = 4;
    localparam int          NUM_ENTRIES  = NUM_LIGHTS * 2;
    localparam logic [3:0]  DEFAULT_TIME = 4'd10;

    localparam logic        COLOR_RED    = 1'b0;
    localparam logic        COLOR_GREEN  = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, stability counter and press pulse
// Purpose: brings a raw board button into the clock domain, accepts a new level
//          only after DEBOUNCE_CYCLES identical samples and emits a one-cycle
//          pulse when the accepted level goes 0 -> 1.
// Ports:   clk       in  system clock
//          rst       in  asynchronous active-low reset
//          btn_raw   in  raw button level
//          btn_pulse out one-cycle pulse per accepted press
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int             CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_primed;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_primed <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (!r_primed) begin
                // First window after reset adopts whatever level the button
                // holds without pulsing, so a press held through reset is not
                // mistaken for a new one.
                if (r_cnt == LAST) begin
                    r_primed <= 1'b1;
                    r_level  <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_pulse <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign btn_pulse = r_pulse;

endmodule

// File: rtl/traffic_cmd_ctrl.sv
// rtl/traffic_cmd_ctrl.sv - operator front-end: timing table, replay burst and run control
// Purpose: debounces load/go/stop, stores switch fields into a 4-light x
//          {red,green} timing table, replays the table as eight inst_send beats
//          on go, then holds is_running until stop.
// Ports:   clk, rst (async active-low)
//          btn_load/btn_go/btn_stop   raw buttons
//          sw_traffic_sel/sw_color_sel/sw_start_color/sw_time   switch fields
//          inst_send, traffic_sel, color_sel, start_color, input_time   beat outputs
//          is_running, cfg_err, busy   status outputs
module traffic_cmd_ctrl
    import traffic_cmd_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_load,
    input  logic       btn_go,
    input  logic       btn_stop,
    input  logic [1:0] sw_traffic_sel,
    input  logic       sw_color_sel,
    input  logic       sw_start_color,
    input  logic [3:0] sw_time,
    output logic       inst_send,
    output logic [1:0] traffic_sel,
    output logic       color_sel,
    output logic       start_color,
    output logic [3:0] input_time,
    output logic       is_running,
    output logic       cfg_err,
    output logic       busy
);

    logic w_load_pulse;
    logic w_go_pulse;
    logic w_stop_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .rst(rst), .btn_raw(btn_load), .btn_pulse(w_load_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_go (
        .clk(clk), .rst(rst), .btn_raw(btn_go), .btn_pulse(w_go_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .clk(clk), .rst(rst), .btn_raw(btn_stop), .btn_pulse(w_stop_pulse)
    );

    state_t                          r_state;
    logic [2:0]                      r_idx;
    logic [NUM_ENTRIES-1:0][3:0]     r_time;
    logic [NUM_LIGHTS-1:0]           r_start;

    logic       r_inst_send;
    logic [1:0] r_traffic_sel;
    logic       r_color_sel;
    logic       r_start_color;
    logic [3:0] r_input_time;
    logic       r_is_running;
    logic       r_cfg_err;
    logic       r_busy;

    // Table entry address is {light, colour}: red at even, green at odd.
    logic [2:0] w_wr_addr;
    logic       w_wr_en;
    logic [2:0] w_beat_idx;
    logic [3:0] w_rd_time;
    logic       w_rd_start;

    assign w_wr_addr  = {sw_traffic_sel, sw_color_sel};
    assign w_wr_en    = (r_state == ST_IDLE) && w_load_pulse && (sw_time != 4'd0);
    // Index of the beat registered on this edge: 0 when leaving IDLE, else next.
    assign w_beat_idx = (r_state == ST_IDLE) ? 3'd0 : r_idx + 3'd1;

    // Forward a same-cycle load into the first beat so load+go replays the new value.
    assign w_rd_time  = (w_wr_en && (w_wr_addr == w_beat_idx)) ? sw_time : r_time[w_beat_idx];
    assign w_rd_start = (w_wr_en && (sw_traffic_sel == w_beat_idx[2:1])) ? sw_start_color
                                                                         : r_start[w_beat_idx[2:1]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_time        <= {NUM_ENTRIES{DEFAULT_TIME}};
            r_start       <= '0;
            r_inst_send   <= 1'b0;
            r_traffic_sel <= 2'd0;
            r_color_sel   <= 1'b0;
            r_start_color <= 1'b0;
            r_input_time  <= 4'd0;
            r_is_running  <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // Beat and data outputs are zero unless a beat is issued this edge.
            r_inst_send   <= 1'b0;
            r_traffic_sel <= 2'd0;
            r_color_sel   <= 1'b0;
            r_start_color <= 1'b0;
            r_input_time  <= 4'd0;
            r_busy        <= 1'b0;

            if (w_wr_en) begin
                r_time[w_wr_addr]       <= sw_time;
                r_start[sw_traffic_sel] <= sw_start_color;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load_pulse) begin
                        r_cfg_err <= (sw_time == 4'd0);
                    end
                    if (w_go_pulse && !w_stop_pulse) begin
                        r_state       <= ST_REPLAY;
                        r_idx         <= 3'd0;
                        r_inst_send   <= 1'b1;
                        r_traffic_sel <= w_beat_idx[2:1];
                        r_color_sel   <= w_beat_idx[0];
                        r_start_color <= w_rd_start;
                        r_input_time  <= w_rd_time;
                        r_busy        <= 1'b1;
                    end
                end
                ST_REPLAY: begin
                    if (w_stop_pulse) begin
                        r_state <= ST_IDLE;
                    end else if (r_idx == 3'd7) begin
                        r_state      <= ST_RUN;
                        r_is_running <= 1'b1;
                    end else begin
                        r_idx         <= w_beat_idx;
                        r_inst_send   <= 1'b1;
                        r_traffic_sel <= w_beat_idx[2:1];
                        r_color_sel   <= w_beat_idx[0];
                        r_start_color <= w_rd_start;
                        r_input_time  <= w_rd_time;
                        r_busy        <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_stop_pulse) begin
                        r_state      <= ST_IDLE;
                        r_is_running <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_is_running <= 1'b0;
                end
            endcase
        end
    end

    assign inst_send   = r_inst_send;
    assign traffic_sel = r_traffic_sel;
    assign color_sel   = r_color_sel;
    assign start_color = r_start_color;
    assign input_time  = r_input_time;
    assign is_running  = r_is_running;
    assign cfg_err     = r_cfg_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_traffic_cmd_ctrl.sv
// tb/tb_traffic_cmd_ctrl.sv - scoreboard bench for traffic_cmd_ctrl
module tb_traffic_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_load, btn_go, btn_stop;
    logic [1:0] sw_traffic_sel;
    logic       sw_color_sel, sw_start_color;
    logic [3:0] sw_time;
    logic       inst_send;
    logic [1:0] traffic_sel;
    logic       color_sel, start_color;
    logic [3:0] input_time;
    logic       is_running, cfg_err, busy;

    traffic_cmd_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .btn_load(btn_load), .btn_go(btn_go), .btn_stop(btn_stop),
        .sw_traffic_sel(sw_traffic_sel), .sw_color_sel(sw_color_sel),
        .sw_start_color(sw_start_color), .sw_time(sw_time),
        .inst_send(inst_send), .traffic_sel(traffic_sel), .color_sel(color_sel),
        .start_color(start_color), .input_time(input_time),
        .is_running(is_running), .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] P_LOAD = 3'b100;
    localparam logic [2:0] P_GO   = 3'b010;
    localparam logic [2:0] P_STOP = 3'b001;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] q_beat [$];
    logic [3:0] m_time [8];
    logic       m_start [4];
    logic       prev_run  = 1'b0;
    logic       prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] all_outs();
        return {inst_send, traffic_sel, color_sel, start_color, input_time,
                is_running, cfg_err, busy};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_time[i] = 4'd10;
        for (int i = 0; i < 4; i++) m_start[i] = 1'b0;
    endtask

    task automatic push_beats(input int n);
        logic [2:0] k;
        for (int i = 0; i < n; i++) begin
            k = 3'(i);
            q_beat.push_back({k[2:1], k[0], m_start[k[2:1]], m_time[k]});
        end
    endtask

    task automatic set_sw(input logic [1:0] sel, input logic col, input logic st, input logic [3:0] t);
        sw_traffic_sel = sel;
        sw_color_sel   = col;
        sw_start_color = st;
        sw_time        = t;
    endtask

    task automatic press(input logic [2:0] m);
        @(negedge clk);
        {btn_load, btn_go, btn_stop} = m;
        repeat (8) @(negedge clk);
        {btn_load, btn_go, btn_stop} = 3'b000;
        repeat (10) @(negedge clk);
    endtask

    // Monitor: pops one expected beat per inst_send and checks run follows the last beat.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (inst_send) begin
                if (q_beat.size() == 0) begin
                    chk("unexpected_beat", 32'({traffic_sel, color_sel, start_color, input_time}), 32'h1ff);
                end else begin
                    chk("beat", 32'({traffic_sel, color_sel, start_color, input_time}), 32'(q_beat.pop_front()));
                end
            end
            if (is_running && !prev_run) chk("run_after_last_beat", 32'(prev_last), 32'd1);
        end
        prev_run  = is_running;
        prev_last = inst_send && (traffic_sel == 2'd3) && color_sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1;
        {btn_load, btn_go, btn_stop} = 3'b000;
        set_sw(2'd0, 1'b0, 1'b0, 4'd0);
        model_reset();
        #1 rst = 1'b0;
        #1 chk("reset_outputs", 32'(all_outs()), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        // Default table replay
        push_beats(8);
        press(P_GO);
        chk("t1_running", 32'(is_running), 32'd1);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_drained", 32'(q_beat.size()), 32'd0);
        press(P_STOP);
        chk("t1_stopped", 32'(is_running), 32'd0);

        // Load light 2 green = 7, start 1
        set_sw(2'd2, 1'b1, 1'b1, 4'd7);
        press(P_LOAD);
        m_time[5] = 4'd7; m_start[2] = 1'b1;
        chk("t2_cfg_err", 32'(cfg_err), 32'd0);
        push_beats(8);
        press(P_GO);
        chk("t2_running", 32'(is_running), 32'd1);
        press(P_STOP);

        // Zero time load rejected, then valid load clears error
        set_sw(2'd1, 1'b0, 1'b1, 4'd0);
        press(P_LOAD);
        chk("t3_cfg_err_set", 32'(cfg_err), 32'd1);
        push_beats(8);
        press(P_GO);
        chk("t3_drained", 32'(q_beat.size()), 32'd0);
        press(P_STOP);
        set_sw(2'd0, 1'b1, 1'b0, 4'd15);
        press(P_LOAD);
        m_time[1] = 4'd15; m_start[0] = 1'b0;
        chk("t3_cfg_err_clr", 32'(cfg_err), 32'd0);

        // Stop lands on beat idx 3: only beats 0..3 appear
        push_beats(4);
        @(negedge clk);
        btn_go = 1'b1;
        repeat (4) @(negedge clk);
        btn_stop = 1'b1;
        repeat (4) @(negedge clk);
        btn_go = 1'b0;
        repeat (4) @(negedge clk);
        btn_stop = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_running", 32'(is_running), 32'd0);
        chk("t4_no_late_beats", 32'(q_beat.size()), 32'd0);

        // Stop and go together in IDLE: stop wins
        press(P_GO | P_STOP);
        chk("stopgo_running", 32'(is_running), 32'd0);
        chk("stopgo_busy", 32'(busy), 32'd0);

        // Load and go together: replay carries the new value
        set_sw(2'd0, 1'b0, 1'b1, 4'd5);
        m_time[0] = 4'd5; m_start[0] = 1'b1;
        push_beats(8);
        press(P_LOAD | P_GO);
        chk("loadgo_running", 32'(is_running), 32'd1);
        chk("loadgo_drained", 32'(q_beat.size()), 32'd0);

        // In RUN: load and go ignored, stop drops run one edge after its pulse
        set_sw(2'd0, 1'b0, 1'b0, 4'd3);
        press(P_LOAD);
        press(P_GO);
        chk("t5_still_running", 32'(is_running), 32'd1);
        chk("t5_cfg_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        btn_stop = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_run_at_pulse", 32'(is_running), 32'd1);
        @(negedge clk);
        chk("t5_run_next_edge", 32'(is_running), 32'd0);
        btn_stop = 1'b0;
        repeat (12) @(negedge clk);
        push_beats(8);
        press(P_GO);
        chk("t5_rerun", 32'(is_running), 32'd1);
        press(P_STOP);

        // Short glitch gives no pulse
        @(negedge clk);
        btn_go = 1'b1;
        repeat (2) @(negedge clk);
        btn_go = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_glitch_busy", 32'(busy), 32'd0);
        chk("t6_glitch_run", 32'(is_running), 32'd0);

        // Reset in the middle of a replay
        push_beats(8);
        @(negedge clk);
        btn_go = 1'b1;
        seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            @(negedge clk);
            if (inst_send) seen = 1;
        end
        if (seen == 0) chk("t6_replay_start_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("t6_reset_outputs", 32'(all_outs()), 32'd0);
        q_beat.delete();
        btn_go = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        push_beats(8);
        press(P_GO);
        chk("t6_default_replay_run", 32'(is_running), 32'd1);
        chk("t6_drained", 32'(q_beat.size()), 32'd0);
        press(P_STOP);
        chk("t6_final_stop", 32'(is_running), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
